// File: rtl/inst_mem_prog_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_prog_pkg
// Shared definitions for the byte-programmed instruction memory:
//   - default geometry (DEPTH / ADDR_W / WORD_BYTES / BYTE_W)
//   - load FSM state encoding (ST_IDLE, ST_LOAD)
//   - fetch error cause bit positions
//   - helper to size the internal byte index
// -----------------------------------------------------------------------------
package inst_mem_prog_pkg;

  localparam int DEF_DEPTH      = 56;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_WORD_BYTES = 4;
  localparam int DEF_BYTE_W     = 8;

  // Load FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  // Fetch error cause vector: one bit per reason a fetch can fail
  localparam int FE_W      = 4;
  localparam int FE_BUSY   = 0;  // fetch while a load is in progress
  localparam int FE_RANGE  = 1;  // word would run past the end of memory
  localparam int FE_ALIGN  = 2;  // address not a multiple of WORD_BYTES
  localparam int FE_PARITY = 3;  // stored parity mismatch (parity build only)

  typedef logic [FE_W-1:0] fetch_cause_t;

  // Width of an index that addresses 0..depth-1 (at least 1 bit)
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_mem_prog_ctrl.sv
// -----------------------------------------------------------------------------
// inst_mem_prog_ctrl
// Load controller: IDLE/LOAD state machine, auto-incrementing write pointer,
// byte counter and sticky overflow flag for the programming port.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_prog_start        pulse: (re)enter LOAD, pointer <= i_prog_base
//   i_prog_base         start byte address of the load
//   i_prog_valid        byte offered on the programming port
//   i_prog_end          pulse: leave LOAD
//   o_prog_ready        byte accepted this cycle (LOAD and no overflow)
//   o_prog_busy         state == LOAD
//   o_prog_ovf          sticky: write attempted with pointer >= DEPTH
//   o_prog_count        bytes written in the current/last load
//   o_wr_en, o_wr_idx   byte-array write strobe and index
// -----------------------------------------------------------------------------
module inst_mem_prog_ctrl
  import inst_mem_prog_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = idx_width(DEF_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_prog_start,
  input  logic [ADDR_W-1:0] i_prog_base,
  input  logic              i_prog_valid,
  input  logic              i_prog_end,
  output logic              o_prog_ready,
  output logic              o_prog_busy,
  output logic              o_prog_ovf,
  output logic [ADDR_W:0]   o_prog_count,
  output logic              o_wr_en,
  output logic [IDX_W-1:0]  o_wr_idx
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  logic [0:0]      r_state;
  logic [ADDR_W:0] r_ptr;    // one extra bit so the pointer can sit at DEPTH
  logic [ADDR_W:0] r_count;
  logic            r_ovf;

  logic w_busy;
  logic w_ready;
  logic w_room;
  logic w_wr_en;
  logic w_ovf_hit;

  assign w_busy  = (r_state == ST_LOAD);
  assign w_ready = w_busy && !r_ovf;
  assign w_room  = (r_ptr < DEPTH_W);

  // A start in the same cycle restarts the load, so the offered byte is dropped.
  assign w_wr_en   = i_prog_valid && w_ready && w_room && !i_prog_start;
  // Reaching DEPTH is fine; only a further attempt raises the overflow.
  assign w_ovf_hit = i_prog_valid && w_busy && !w_room && !i_prog_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_prog_start) begin
      // start wins over a simultaneous end
      r_state <= ST_LOAD;
      r_ptr   <= {1'b0, i_prog_base};
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_ptr   <= r_ptr + ONE_W;
        r_count <= r_count + ONE_W;
      end
      if (w_ovf_hit) begin
        r_ovf <= 1'b1;
      end
      // a byte offered together with end is still written above
      if (i_prog_end && w_busy) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign o_prog_ready = w_ready;
  assign o_prog_busy  = w_busy;
  assign o_prog_ovf   = r_ovf;
  assign o_prog_count = r_count;
  assign o_wr_en      = w_wr_en;
  assign o_wr_idx     = r_ptr[IDX_W-1:0];

endmodule

// File: rtl/inst_mem_prog.sv
// -----------------------------------------------------------------------------
// inst_mem_prog
// Byte-programmed instruction memory with a clocked fetch port. Bytes arrive
// from the programming front-end through a load FSM (inst_mem_prog_ctrl);
// the fetch port returns a little-endian word one cycle after the request.
//
// Optional build macro: INST_MEM_PARITY_EN
//   Stores an even-parity bit per byte; a fetch whose bytes fail parity
//   returns the data with o_fetch_err = 1.
//
// Ports:
//   i_clk, i_rst_n                       clock, asynchronous active-low reset
//   i_prog_start / i_prog_base           begin a load at a byte address
//   i_prog_valid / i_prog_data           byte stream, accepted with o_prog_ready
//   i_prog_end                           finish the load
//   o_prog_ready, o_prog_busy            handshake / LOAD state
//   o_prog_ovf, o_prog_count             sticky overflow, bytes written
//   i_fetch_en / i_fetch_addr            fetch request (byte address)
//   o_fetch_data                         word, mem[a] in the low byte
//   o_fetch_valid, o_fetch_err           response strobe and error flag
// -----------------------------------------------------------------------------
module inst_mem_prog
  import inst_mem_prog_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int BYTE_W     = DEF_BYTE_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_prog_start,
  input  logic [ADDR_W-1:0]            i_prog_base,
  input  logic                         i_prog_valid,
  input  logic [BYTE_W-1:0]            i_prog_data,
  output logic                         o_prog_ready,
  input  logic                         i_prog_end,
  output logic                         o_prog_busy,
  output logic                         o_prog_ovf,
  output logic [ADDR_W:0]              o_prog_count,
  input  logic                         i_fetch_en,
  input  logic [ADDR_W-1:0]            i_fetch_addr,
  output logic [WORD_BYTES*BYTE_W-1:0] o_fetch_data,
  output logic                         o_fetch_valid,
  output logic                         o_fetch_err
);

  localparam int IDX_W  = idx_width(DEPTH);
  localparam int WORD_W = WORD_BYTES * BYTE_W;

  // ---------------------------------------------------------------------------
  // Load controller
  // ---------------------------------------------------------------------------
  logic             w_busy;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;

  inst_mem_prog_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_ctrl (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_prog_start (i_prog_start),
    .i_prog_base  (i_prog_base),
    .i_prog_valid (i_prog_valid),
    .i_prog_end   (i_prog_end),
    .o_prog_ready (o_prog_ready),
    .o_prog_busy  (w_busy),
    .o_prog_ovf   (o_prog_ovf),
    .o_prog_count (o_prog_count),
    .o_wr_en      (w_wr_en),
    .o_wr_idx     (w_wr_idx)
  );

  assign o_prog_busy = w_busy;

  // ---------------------------------------------------------------------------
  // Byte array (contents survive reset)
  // ---------------------------------------------------------------------------
  logic [BYTE_W-1:0] r_mem [DEPTH];
`ifdef INST_MEM_PARITY_EN
  logic              r_par [DEPTH];
`endif

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= i_prog_data;
`ifdef INST_MEM_PARITY_EN
      // even parity: byte plus parity bit has an even number of ones
      r_par[w_wr_idx] <= ^i_prog_data;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch path
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0]   w_fetch_end;
  fetch_cause_t      w_cause;
  logic              w_reject;
  logic [WORD_W-1:0] w_word;
`ifdef INST_MEM_PARITY_EN
  logic [WORD_BYTES-1:0] w_byte_bad;
`endif

  // Bytes of the addressed word; indices are only meaningful when the fetch
  // is in range and aligned, otherwise the word is discarded.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_rd
      logic [IDX_W-1:0] w_idx;
      assign w_idx = i_fetch_addr[IDX_W-1:0] + IDX_W'(gi);
      assign w_word[gi*BYTE_W +: BYTE_W] = r_mem[w_idx];
`ifdef INST_MEM_PARITY_EN
      assign w_byte_bad[gi] = ^{r_mem[w_idx], r_par[w_idx]};
`endif
    end
  endgenerate

  // End address computed one bit wider so the range check cannot wrap.
  assign w_fetch_end        = {1'b0, i_fetch_addr} + (ADDR_W+1)'(WORD_BYTES);
  assign w_cause[FE_BUSY]   = w_busy;
  assign w_cause[FE_RANGE]  = (w_fetch_end > (ADDR_W+1)'(DEPTH));
  assign w_cause[FE_ALIGN]  = ((i_fetch_addr % ADDR_W'(WORD_BYTES)) != '0);
`ifdef INST_MEM_PARITY_EN
  assign w_cause[FE_PARITY] = |w_byte_bad;
`else
  assign w_cause[FE_PARITY] = 1'b0;
`endif

  // Parity is not a reject: the data is still returned with the error flag.
  assign w_reject = w_cause[FE_BUSY] | w_cause[FE_RANGE] | w_cause[FE_ALIGN];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fetch_data  <= '0;
      o_fetch_valid <= 1'b0;
      o_fetch_err   <= 1'b0;
    end else begin
      o_fetch_valid <= i_fetch_en;
      o_fetch_err   <= 1'b0;
      if (i_fetch_en) begin
        if (w_reject) begin
          o_fetch_data <= '0;
          o_fetch_err  <= 1'b1;
        end else begin
          o_fetch_data <= w_word;
          o_fetch_err  <= w_cause[FE_PARITY];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_prog.sv
module tb_inst_mem_prog;

  localparam int DEPTH = 56;
  localparam int ADDR_W = 8;
  localparam int WB = 4;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              prog_start = 1'b0;
  logic [ADDR_W-1:0] prog_base = '0;
  logic              prog_valid = 1'b0;
  logic [BW-1:0]     prog_data = '0;
  logic              prog_ready;
  logic              prog_end = 1'b0;
  logic              prog_busy;
  logic              prog_ovf;
  logic [ADDR_W:0]   prog_count;
  logic              fetch_en = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [WB*BW-1:0]  fetch_data;
  logic              fetch_valid;
  logic              fetch_err;

  inst_mem_prog dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_prog_start (prog_start),
    .i_prog_base  (prog_base),
    .i_prog_valid (prog_valid),
    .i_prog_data  (prog_data),
    .o_prog_ready (prog_ready),
    .i_prog_end   (prog_end),
    .o_prog_busy  (prog_busy),
    .o_prog_ovf   (prog_ovf),
    .o_prog_count (prog_count),
    .i_fetch_en   (fetch_en),
    .i_fetch_addr (fetch_addr),
    .o_fetch_data (fetch_data),
    .o_fetch_valid(fetch_valid),
    .o_fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: byte image plus a flag per byte saying the bench wrote it
  logic [7:0] m_mem   [DEPTH];
  bit         m_known [DEPTH];
  logic [7:0] ld_data [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit word_known(input int a);
    for (int k = 0; k < WB; k++) if (!m_known[a+k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_word(input int a);
    logic [31:0] w = '0;
    for (int k = 0; k < WB; k++) w[k*8 +: 8] = m_mem[a+k];
    return w;
  endfunction

  // One fetch; expectation derived from the address rules and the model image
  task automatic do_fetch(input int a, input bit in_load);
    bit exp_err;
    fetch_en = 1'b1;
    fetch_addr = ADDR_W'(a);
    tick();
    fetch_en = 1'b0;
    exp_err = in_load || (a % WB != 0) || (a + WB > DEPTH);
    chk("fetch_valid", fetch_valid, 1);
    chk("fetch_err", fetch_err, exp_err);
    if (exp_err) chk("fetch_data_err", fetch_data, 0);
    else if (word_known(a)) chk("fetch_data", fetch_data, model_word(a));
    $display("fetch addr=%0d load=%0b data=0x%08h err=%0b", a, in_load, fetch_data, fetch_err);
  endtask

  // Load n bytes of ld_data at base. end_mode: 0 = end pulse afterwards,
  // 1 = end together with the last byte, 2 = stay in LOAD.
  task automatic do_load(input int base, input int n, input bit gaps, input int end_mode);
    int cap;
    int wrote;
    bit ovf;
    cap = (base >= DEPTH) ? 0 : DEPTH - base;
    prog_start = 1'b1;
    prog_base = ADDR_W'(base);
    tick();
    prog_start = 1'b0;
    chk("start_busy", prog_busy, 1);
    chk("start_ready", prog_ready, 1);
    chk("start_count", prog_count, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) tick();
      prog_valid = 1'b1;
      prog_data = ld_data[i];
      prog_end = (end_mode == 1) && (i == n - 1);
      tick();
      prog_valid = 1'b0;
      prog_end = 1'b0;
      wrote = (i + 1 < cap) ? i + 1 : cap;
      ovf = (i + 1) > cap;
      chk("load_count", prog_count, wrote);
      chk("load_ovf", prog_ovf, ovf);
      if (!(end_mode == 1 && i == n - 1)) chk("load_ready", prog_ready, !ovf);
    end
    for (int i = 0; i < n && i < cap; i++) begin
      m_mem[base+i] = ld_data[i];
      m_known[base+i] = 1'b1;
    end
    if (end_mode == 0) begin
      prog_end = 1'b1;
      tick();
      prog_end = 1'b0;
    end
    if (end_mode != 2) begin
      chk("end_busy", prog_busy, 0);
      chk("end_ready", prog_ready, 0);
    end
    $display("load base=%0d n=%0d end_mode=%0d count=%0d ovf=%0b", base, n, end_mode, prog_count, prog_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b0;
    end

    // ---- reset state
    tick();
    tick();
    chk("rst_busy", prog_busy, 0);
    chk("rst_ready", prog_ready, 0);
    chk("rst_ovf", prog_ovf, 0);
    chk("rst_count", prog_count, 0);
    chk("rst_fvalid", fetch_valid, 0);
    chk("rst_ferr", fetch_err, 0);
    chk("rst_fdata", fetch_data, 0);
    rst_n = 1'b1;
    tick();

    // ---- two RISC-V instructions at base 0
    ld_data[0] = 8'h13; ld_data[1] = 8'h00; ld_data[2] = 8'h00; ld_data[3] = 8'h00;
    ld_data[4] = 8'h93; ld_data[5] = 8'h80; ld_data[6] = 8'h10; ld_data[7] = 8'h00;
    do_load(0, 8, 1'b0, 0);
    chk("t1_count", prog_count, 8);
    do_fetch(0, 1'b0);
    chk("t1_word0", fetch_data, 32'h0000_0013);
    tick();
    chk("hold_valid", fetch_valid, 0);
    chk("hold_err", fetch_err, 0);
    chk("hold_data", fetch_data, 32'h0000_0013);
    do_fetch(4, 1'b0);
    chk("t1_word1", fetch_data, 32'h0010_8093);

    // ---- overflow at the top of memory
    for (int i = 0; i < 5; i++) ld_data[i] = 8'($urandom);
    do_load(52, 5, 1'b0, 0);
    chk("ovf_sticky", prog_ovf, 1);
    chk("ovf_count", prog_count, 4);
    do_fetch(52, 1'b0);
    do_fetch(56, 1'b0);

    // ---- misaligned, and fetch during LOAD
    do_fetch(2, 1'b0);
    prog_start = 1'b1;
    prog_base = '0;
    tick();
    prog_start = 1'b0;
    chk("ld_busy", prog_busy, 1);
    do_fetch(0, 1'b1);
    prog_end = 1'b1;
    tick();
    prog_end = 1'b0;
    chk("ld_end_busy", prog_busy, 0);

    // ---- valid together with end on the 4th byte
    ld_data[0] = 8'hAA; ld_data[1] = 8'hBB; ld_data[2] = 8'hCC; ld_data[3] = 8'hDD;
    do_load(8, 4, 1'b0, 1);
    chk("ve_count", prog_count, 4);
    do_fetch(8, 1'b0);
    chk("ve_word", fetch_data, 32'hDDCC_BBAA);

    // ---- start and end together in IDLE: start wins
    prog_start = 1'b1;
    prog_end = 1'b1;
    prog_base = 8'd20;
    tick();
    prog_start = 1'b0;
    prog_end = 1'b0;
    chk("se_busy", prog_busy, 1);
    prog_end = 1'b1;
    tick();
    prog_end = 1'b0;
    chk("se_end_busy", prog_busy, 0);

    // ---- reset in the middle of a load
    ld_data[0] = 8'h11; ld_data[1] = 8'h22; ld_data[2] = 8'h33;
    do_load(0, 3, 1'b0, 2);
    chk("mr_count", prog_count, 3);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", prog_busy, 0);
    chk("mr_ready", prog_ready, 0);
    chk("mr_count0", prog_count, 0);
    chk("mr_ovf", prog_ovf, 0);
    chk("mr_fvalid", fetch_valid, 0);
    chk("mr_fdata", fetch_data, 0);
    #2;
    rst_n = 1'b1;
    tick();
    do_fetch(0, 1'b0);
    chk("mr_low24", fetch_data[23:0], 24'h33_2211);

    // ---- randomized: full image, fetches, then partial loads and more fetches
    for (int i = 0; i < DEPTH; i++) ld_data[i] = 8'($urandom);
    do_load(0, DEPTH, 1'b1, 0);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) do_fetch(4 * $urandom_range(0, 15), 1'b0);
      else do_fetch($urandom_range(0, 63), 1'b0);
    end
    for (int t = 0; t < 4; t++) begin
      int b;
      int n;
      b = $urandom_range(0, 60);
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) ld_data[i] = 8'($urandom);
      do_load(b, n, 1'b1, $urandom_range(0, 1));
      for (int f = 0; f < 5; f++) do_fetch(4 * $urandom_range(0, 14), 1'b0);
    end

`ifdef INST_MEM_PARITY_EN
    // ---- corrupt a stored byte behind the parity bit's back
    dut.r_mem[4] = dut.r_mem[4] ^ 8'h01;
    fetch_en = 1'b1;
    fetch_addr = 8'd4;
    tick();
    fetch_en = 1'b0;
    chk("par_valid", fetch_valid, 1);
    chk("par_err", fetch_err, 1);
    chk("par_data", fetch_data, model_word(4) ^ 32'h1);
    $display("parity fetch addr=4 data=0x%08h err=%0b", fetch_data, fetch_err);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
